// File: rtl/reset_seq.sv
// Staggered peripheral reset release controller: releases NUM_STAGES resets one at a time, ce-paced.
// Optional: define RESET_SEQ_SKIP_MASKED_EN to release masked stages without waiting out a delay slot.
`timescale 1ns/1ps
module reset_seq #(
  parameter logic [4:0]  BASE_ADDR  = 5'h1d,
  parameter int unsigned NUM_STAGES = 4,
  parameter logic [3:0]  DFL_DELAY  = 4'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic                  assert_all,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [4:0]            csr_a,
  input  logic [7:0]            csr_di,
  input  logic                  csr_we,
  output logic [7:0]            csr_do,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_XW = CNT_W + 1;
  localparam logic [4:0]  ADDR_HOLD = 5'(BASE_ADDR + 5'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] released_q, released_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      delay_q;
  logic [NUM_STAGES-1:0] hold_q;

  logic                  sel_main;
  logic                  sel_hold;
  logic                  restart_wr;
  logic                  go;
  logic [CNT_W-1:0]      delay_eff;
  logic [CNT_XW-1:0]     cnt_inc;
  logic                  skip;
  logic                  slot_done;
  logic                  unused_csr_di;

  // CSR decode; restart bit behaves exactly like a start pulse
  assign sel_main   = (csr_a == BASE_ADDR);
  assign sel_hold   = (csr_a == ADDR_HOLD);
  assign restart_wr = csr_we & sel_main & csr_di[5];
  assign go         = start | restart_wr;
  assign unused_csr_di = ^{csr_di[7:6], csr_di[4]};

  // delay of zero is treated as one tick; widened compare never wraps when delay drops
  assign delay_eff = (delay_q == '0) ? CNT_W'(1) : delay_q;
  assign cnt_inc   = CNT_XW'(cnt_q) + CNT_XW'(1);

`ifdef RESET_SEQ_SKIP_MASKED_EN
  assign skip = stage_mask[idx_q];
`else
  assign skip = 1'b0;
`endif

  assign slot_done = skip | (ce & (cnt_inc >= {1'b0, delay_eff}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      released_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      released_q <= released_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    released_d = released_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        released_d = '0;
        if (go) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (slot_done) begin
          released_d[idx_q] = 1'b1;
          cnt_d             = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (ce) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (go) begin
          state_d    = ST_WAIT;
          released_d = '0;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        released_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase

    // assert_all overrides everything, including a same-cycle start or restart
    if (assert_all) begin
      state_d    = ST_IDLE;
      released_d = '0;
      idx_d      = '0;
      cnt_d      = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // CSR-writable configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= DFL_DELAY;
      hold_q  <= '0;
    end else if (csr_we) begin
      if (sel_main) delay_q <= csr_di[CNT_W-1:0];
      if (sel_hold) hold_q  <= csr_di[NUM_STAGES-1:0];
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (sel_main) begin
      csr_do = {busy_q, done_q, 1'b0, 1'b0, delay_q};
    end else if (sel_hold) begin
      csr_do = 8'(hold_q);
    end
  end

  assign rst_out = ~released_q | hold_q | stage_mask;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: tick-counting reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_reset_seq;

  localparam int         N      = 4;
  localparam logic [4:0] BASE   = 5'h1d;
  localparam logic [4:0] HOLD_A = 5'h1e;
`ifdef RESET_SEQ_SKIP_MASKED_EN
  localparam int EXP_MASK_CE = 12;
`else
  localparam int EXP_MASK_CE = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         start = 1'b0;
  logic         assert_all = 1'b0;
  logic [N-1:0] stage_mask = '0;
  logic [4:0]   csr_a = 5'h00;
  logic [7:0]   csr_di = 8'h00;
  logic         csr_we = 1'b0;
  logic [7:0]   csr_do;
  logic [N-1:0] rst_out;
  logic         busy;
  logic         done;

  int n_chk = 0;
  int n_err = 0;

  reset_seq #(.BASE_ADDR(BASE), .NUM_STAGES(N), .DFL_DELAY(4'd4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .assert_all(assert_all),
    .stage_mask(stage_mask), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .rst_out(rst_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0=idle 1=running 2=finished; m_k stages released, m_ticks ce seen in current slot
  int         m_phase = 0;
  int         m_k = 0;
  int         m_ticks = 0;
  logic [3:0] m_delay = 4'd4;
  logic [N-1:0] m_hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_k     <= 0;
      m_ticks <= 0;
      m_delay <= 4'd4;
      m_hold  <= '0;
    end else begin
      automatic int eff = (m_delay == 4'd0) ? 1 : int'(m_delay);
      automatic bit go  = start || (csr_we && csr_a == BASE && csr_di[5]);
      automatic int np  = m_phase;
      automatic int nk  = m_k;
      automatic int nt  = m_ticks;
      automatic bit skp = 1'b0;
`ifdef RESET_SEQ_SKIP_MASKED_EN
      if (m_phase == 1) skp = stage_mask[m_k];
`endif
      if (assert_all) begin
        np = 0; nk = 0; nt = 0;
      end else if (m_phase != 1) begin
        if (go) begin np = 1; nk = 0; nt = 0; end
      end else if (skp || (ce && (m_ticks + 1 >= eff))) begin
        nk = m_k + 1;
        nt = 0;
        if (nk == N) np = 2;
      end else if (ce) begin
        nt = m_ticks + 1;
      end
      m_phase <= np;
      m_k     <= nk;
      m_ticks <= nt;
      if (csr_we && csr_a == BASE)   m_delay <= csr_di[3:0];
      if (csr_we && csr_a == HOLD_A) m_hold  <= csr_di[N-1:0];
    end
  end

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] rel;
    if (m_phase == 0)      rel = '0;
    else if (m_phase == 2) rel = '1;
    else                   rel = N'((1 << m_k) - 1);
    return ~rel | m_hold | stage_mask;
  endfunction

  function automatic logic [7:0] exp_csr();
    if (csr_a == BASE)   return {m_phase == 1, m_phase == 2, 2'b00, m_delay};
    if (csr_a == HOLD_A) return 8'(m_hold);
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    chk("cyc_rst_out", 32'(rst_out), 32'(exp_rst()));
    chk("cyc_busy", 32'(busy), 32'(m_phase == 1));
    chk("cyc_done", 32'(done), 32'(m_phase == 2));
    chk("cyc_csr_do", 32'(csr_do), 32'(exp_csr()));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ce(input int n);
    repeat (n) begin
      cyc(7);
      ce = 1'b1;
      cyc(1);
      ce = 1'b0;
    end
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    cyc(1);
    csr_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic csr_rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(nm, 32'(csr_do), 32'(exp));
  endtask

  logic [N-1:0] stage_exp [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
  int n_ce;

  initial begin
    cyc(3);
    chk("reset_rst_out", 32'(rst_out), 32'h0F);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    cyc(2);
    csr_rd_chk("reset_csr_main", BASE, 8'h04);

    // default delay 4, ce every 8 clk
    pulse_start();
    chk("t1_busy", 32'(busy), 32'h1);
    for (int s = 0; s < N; s++) begin
      run_ce(4);
      chk($sformatf("t1_stage%0d", s), 32'(rst_out), 32'(stage_exp[s]));
    end
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy_end", 32'(busy), 32'h0);
    csr_rd_chk("t1_csr", BASE, 8'h44);

    // delay 0 acts as one stage per ce
    csr_wr(BASE, 8'h00);
    pulse_start();
    chk("t2_restart_rst", 32'(rst_out), 32'h0F);
    chk("t2_restart_done", 32'(done), 32'h0);
    for (int s = 0; s < N; s++) begin
      run_ce(1);
      chk($sformatf("t2_stage%0d", s), 32'(rst_out), 32'(stage_exp[s]));
    end
    chk("t2_done", 32'(done), 32'h1);
    csr_rd_chk("t2_csr", BASE, 8'h40);

    // restart via CSR, start ignored mid-WAIT, delay lowered with cnt=3
    csr_wr(BASE, 8'h24);
    chk("t3_busy", 32'(busy), 32'h1);
    run_ce(3);
    chk("t3_cnt3", 32'(rst_out), 32'h0F);
    pulse_start();
    csr_wr(BASE, 8'h02);
    run_ce(1);
    chk("t3_lowered", 32'(rst_out), 32'h0E);
    run_ce(1);
    chk("t3_slot2_half", 32'(rst_out), 32'h0E);
    run_ce(1);
    chk("t3_slot2_full", 32'(rst_out), 32'h0C);
    run_ce(4);
    chk("t3_final", 32'(rst_out), 32'h00);
    chk("t3_done", 32'(done), 32'h1);

    // assert_all beats start and restart writes
    start = 1'b1; assert_all = 1'b1;
    cyc(1);
    start = 1'b0; assert_all = 1'b0;
    chk("t4_rst", 32'(rst_out), 32'h0F);
    chk("t4_done", 32'(done), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    run_ce(5);
    chk("t4_no_seq", 32'(busy), 32'h0);
    csr_a = BASE; csr_di = 8'h22; csr_we = 1'b1; assert_all = 1'b1;
    cyc(1);
    csr_we = 1'b0; assert_all = 1'b0;
    run_ce(3);
    chk("t4_restart_dropped", 32'(busy), 32'h0);
    chk("t4_restart_rst", 32'(rst_out), 32'h0F);
    pulse_start();
    run_ce(3);
    chk("t4_mid_rst", 32'(rst_out), 32'h0E);
    assert_all = 1'b1;
    cyc(1);
    assert_all = 1'b0;
    chk("t4_abort_rst", 32'(rst_out), 32'h0F);
    chk("t4_abort_busy", 32'(busy), 32'h0);

    // masked and held stages
    csr_wr(BASE, 8'h04);
    stage_mask = 4'b0100;
    csr_wr(HOLD_A, 8'hF1);
    csr_rd_chk("t5_hold_rd", HOLD_A, 8'h01);
    pulse_start();
    n_ce = 0;
    while (!done && n_ce < 40) begin
      run_ce(1);
      n_ce++;
    end
    chk("t5_ce_count", 32'(n_ce), 32'(EXP_MASK_CE));
    chk("t5_final_rst", 32'(rst_out), 32'h05);

    // async reset mid-WAIT
    pulse_start();
    run_ce(5);
    chk("t6_busy_pre", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_imm", 32'(rst_out), 32'h0F);
    chk("t6_busy_imm", 32'(busy), 32'h0);
    chk("t6_done_imm", 32'(done), 32'h0);
    cyc(1);
    csr_rd_chk("t6_csr_main", BASE, 8'h04);
    csr_rd_chk("t6_csr_hold", HOLD_A, 8'h00);
    csr_rd_chk("t6_csr_unaddr", 5'h03, 8'h00);
    cyc(1);
    csr_rd_chk("t6_csr_1f", 5'h1f, 8'h00);
    cyc(1);
    rst_n = 1'b1;
    stage_mask = '0;
    cyc(2);
    pulse_start();
    run_ce(16);
    chk("t6_recover_rst", 32'(rst_out), 32'h00);
    chk("t6_recover_done", 32'(done), 32'h1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
